// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin front end for one shared add/sub datapath.
// A single registered result slot holds the last result, its flags and the issuing requester id.
module alu_share_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_sub,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_sub,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             rsp_overflow
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q;
  logic             last_grant_q;
  logic             id_q, carry_q, zero_q, ovf_q;
  logic [WIDTH-1:0] result_q;

  logic             can_accept, sel1, grant;
  logic [WIDTH-1:0] a_d, b_d, bx_d, result_d;
  logic             sub_d, carry_d, zero_d, ovf_d;

  // The slot can be drained and refilled on the same edge.
  assign can_accept = ~rst & ((state_q == EMPTY) | rsp_ready);
  assign sel1       = req1_valid & (~req0_valid | ~last_grant_q);
  assign req0_ready = can_accept & req0_valid & ~sel1;
  assign req1_ready = can_accept & sel1;
  assign grant      = req0_ready | req1_ready;

  always_comb begin
    a_d   = sel1 ? req1_a   : req0_a;
    b_d   = sel1 ? req1_b   : req0_b;
    sub_d = sel1 ? req1_sub : req0_sub;
    bx_d  = b_d ^ {WIDTH{sub_d}};
    {carry_d, result_d} = {1'b0, a_d} + {1'b0, bx_d} + {{WIDTH{1'b0}}, sub_d};
    ovf_d  = (a_d[WIDTH-1] == bx_d[WIDTH-1]) & (result_d[WIDTH-1] != a_d[WIDTH-1]);
    zero_d = ~|result_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      result_q     <= '0;
      carry_q      <= 1'b0;
      zero_q       <= 1'b0;
      ovf_q        <= 1'b0;
    end else if (grant) begin
      state_q      <= FULL;
      last_grant_q <= sel1;
      id_q         <= sel1;
      result_q     <= result_d;
      carry_q      <= carry_d;
      zero_q       <= zero_d;
      ovf_q        <= ovf_d;
    end else if (rsp_ready) begin
      state_q      <= EMPTY;
    end
  end

  assign rsp_valid    = (state_q == FULL);
  assign rsp_id       = id_q;
  assign rsp_result   = result_q;
  assign rsp_carry    = carry_q;
  assign rsp_zero     = zero_q;
  assign rsp_overflow = ovf_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed plus randomized bench for alu_share_arbiter against an arithmetic reference model.
module tb_alu_share_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_sub;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_sub;
  logic [31:0] req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_zero, rsp_overflow;
  logic [31:0] rsp_result;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit          m_full, m_last, m_id, m_c, m_z, m_o, m_rst_seen;
  logic [31:0] m_res;

  alu_share_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sub(req0_sub),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sub(req1_sub),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
    .rsp_overflow(rsp_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Plain integer arithmetic: unsigned for result/carry, signed range test for overflow.
  task automatic ref_op(input logic [31:0] a, input logic [31:0] b, input bit sub,
                        output logic [31:0] r, output bit c, output bit z, output bit o);
    longint unsigned ua, ub, full;
    longint sa, sb, s;
    ua = a; ub = b;
    sa = $signed(a); sb = $signed(b);
    if (sub) begin
      full = ua - ub;
      c = (ua >= ub);
      s = sa - sb;
    end else begin
      full = ua + ub;
      c = (full >= 64'h1_0000_0000);
      s = sa + sb;
    end
    r = full[31:0];
    z = (r == 32'd0);
    o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endtask

  task automatic cyc(input bit r, input bit v0, input bit s0, input logic [31:0] a0,
                     input logic [31:0] b0, input bit v1, input bit s1,
                     input logic [31:0] a1, input logic [31:0] b1, input bit rr);
    bit can, w1, e0, e1;
    @(negedge clk);
    rst = r; rsp_ready = rr;
    req0_valid = v0; req0_sub = s0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_sub = s1; req1_a = a1; req1_b = b1;
    #1;
    can = !r && (!m_full || rr);
    w1  = (v0 && v1) ? (m_last == 1'b0) : v1;
    e0  = can && v0 && !w1;
    e1  = can && v1 && w1;
    chk("req0_ready", req0_ready, e0);
    chk("req1_ready", req1_ready, e1);
    @(posedge clk);
    if (r) begin
      m_full = 0; m_last = 1; m_id = 0; m_res = 0; m_c = 0; m_z = 0; m_o = 0;
      m_rst_seen = 1;
    end else if (e0 || e1) begin
      m_full = 1; m_last = w1; m_id = w1;
      if (w1) ref_op(a1, b1, s1, m_res, m_c, m_z, m_o);
      else    ref_op(a0, b0, s0, m_res, m_c, m_z, m_o);
      m_rst_seen = 0;
    end else if (rr) begin
      m_full = 0;
    end
    #1;
    chk("rsp_valid", rsp_valid, m_full);
    if (m_full || m_rst_seen) begin
      chk("rsp_id", rsp_id, m_id);
      chk("rsp_result", rsp_result, m_res);
      chk("rsp_carry", rsp_carry, m_c);
      chk("rsp_zero", rsp_zero, m_z);
      chk("rsp_overflow", rsp_overflow, m_o);
    end
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 7));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1; rsp_ready = 0;
    req0_valid = 0; req0_sub = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_sub = 0; req1_a = 0; req1_b = 0;
    m_full = 0; m_last = 1; m_id = 0; m_res = 0; m_c = 0; m_z = 0; m_o = 0; m_rst_seen = 0;

    // reset, with a requester already valid (ready must stay low)
    cyc(1, 1, 0, 32'd1, 32'd1, 1, 0, 32'd2, 32'd2, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // 1: req0 add 5+3
    cyc(0, 1, 0, 32'd5, 32'd3, 0, 0, 0, 0, 0);
    chk("t1_result", rsp_result, 32'd8);
    chk("t1_id", rsp_id, 1'b0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // 2: req1 subtractions, back to back with rsp_ready high
    cyc(0, 0, 0, 0, 0, 1, 1, 32'd3, 32'd3, 1);
    chk("t2_zero", rsp_zero, 1'b1);
    cyc(0, 0, 0, 0, 0, 1, 1, 32'd5, 32'd3, 1);
    chk("t2_res52", rsp_result, 32'd2);
    cyc(0, 0, 0, 0, 0, 1, 1, 32'd3, 32'd5, 1);
    chk("t2_res35", rsp_result, 32'hFFFF_FFFE);
    chk("t2_carry35", rsp_carry, 1'b0);

    // 3: overflow and carry corners
    cyc(0, 1, 0, 32'h7FFF_FFFF, 32'd1, 0, 0, 0, 0, 1);
    chk("t3_ovf_add", rsp_overflow, 1'b1);
    cyc(0, 1, 0, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 0, 1);
    chk("t3_carry_add", rsp_carry, 1'b1);
    cyc(0, 0, 0, 0, 0, 1, 1, 32'h8000_0000, 32'd1, 1);
    chk("t3_ovf_sub", rsp_overflow, 1'b1);
    chk("t3_res_sub", rsp_result, 32'h7FFF_FFFF);

    // 4: both valid, rsp_ready high -> alternating grants
    for (int i = 0; i < 8; i++)
      cyc(0, 1, 0, $urandom, $urandom, 1, 1, $urandom, $urandom, 1);

    // 5: backpressure then release
    for (int i = 0; i < 5; i++)
      cyc(0, 1, 0, $urandom, $urandom, 1, 0, $urandom, $urandom, 0);
    cyc(0, 1, 0, 32'd10, 32'd20, 1, 0, 32'd30, 32'd40, 1);

    // 6: reset while full with both requesting; first grant afterwards to req0
    cyc(0, 1, 0, 32'd1, 32'd2, 1, 0, 32'd3, 32'd4, 0);
    cyc(1, 1, 0, 32'd1, 32'd2, 1, 0, 32'd3, 32'd4, 0);
    cyc(0, 1, 0, 32'd7, 32'd8, 1, 1, 32'd9, 32'd1, 1);
    chk("t6_id", rsp_id, 1'b0);
    chk("t6_result", rsp_result, 32'd15);

    // randomized traffic with occasional reset
    for (int i = 0; i < 400; i++)
      cyc(($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom), rnd32(), rnd32(),
          1'($urandom), 1'($urandom), rnd32(), rnd32(), ($urandom_range(0, 3) != 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
